pc_gen_unit: RTL and testbench
==============================

// Module: pc_gen_unit
// PURPOSE
//  Parametrised fetch-PC generator: PC register and next-PC select in one block, with stall,
//  halt/resume and trap redirect. Feeds the instruction-fetch stage.
//  Redirect sources come from execute (jump, branch) and the trap controller.
//  A valid/ready handshake tells fetch when the current PC is consumed.
// PARAMETERS
//  XLEN          32   address width in bits
//  RESET_VECTOR  0    PC value loaded by reset (XLEN bits)
//  INC           4    sequential increment in bytes
// PORTS
//  clk                     in   1     rising-edge clock
//  reset                   in   1     asynchronous, active-high reset
//  stall                   in   1     hold PC (blocks sequential advance only)
//  halt_req                in   1     request to enter HALT
//  resume                  in   1     leave HALT at held PC
//  trap                    in   1     trap redirect request
//  trap_vector             in   XLEN  trap target address
//  jump                    in   1     JAL/JALR redirect
//  branch_condition_match  in   1     taken-branch redirect
//  target_addr             in   XLEN  jump/branch target (PC+imm or rs1+imm)
//  fetch_ready             in   1     fetch accepts pc this cycle
//  pc                      out  XLEN  current fetch PC
//  pc_valid                out  1     pc is a valid fetch request
//  pc_increment            out  XLEN  pc + INC, combinational
//  redirect                out  1     registered pulse: PC redirected last edge (fetch flush)
//  halted                  out  1     FSM in HALT
//  misalign_fault          out  1     registered fault pulse (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): pc=RESET_VECTOR, state=BOOT, pc_valid=0, redirect=0, halted=0, misalign_fault=0.
//  - fire = pc_valid & fetch_ready.
//  - FSM states BOOT, RUN, HALT:
//    BOOT: pc_valid=0; next edge -> RUN. Redirect inputs are ignored in BOOT.
//    RUN: pc_valid=1. halt_req -> HALT. Any redirect in the same cycle is applied first,
//      then the FSM halts at the new PC.
//    HALT: pc_valid=0, halted=1, pc held.
//      trap -> pc=trap_vector, RUN, redirect=1.
//      resume -> RUN with pc unchanged.
//      jump, branch and stall are ignored.
//  - Next-PC priority in RUN:
//    1. trap -> trap_vector
//    2. jump -> {target_addr[XLEN-1:1],1'b0}
//    3. branch_condition_match -> {target_addr[XLEN-1:1],1'b0}
//    4. fire & ~stall -> pc_increment
//    5. otherwise hold
//  - Redirects (priorities 1-3) apply regardless of stall and fetch_ready.
//    redirect is 1 in the cycle after any redirect load, otherwise 0.
//  - pc_increment = (pc + INC) mod 2^XLEN. Wrap-around is silent: 0xFFFFFFFC -> 0x00000000.
//  - Latency: a redirect input at edge N gives the new pc visible after edge N. No bubble is
//    inserted beyond the redirect pulse.
//  - Reset asserted mid-operation overrides everything immediately, including HALT.
// CONFIGURATION
//  PC_MISALIGN_CHECK_EN defined:
//    - A jump or branch whose cleared target has bit[1]=1 is not taken.
//    - pc loads trap_vector, redirect=1, and misalign_fault pulses 1 cycle.
//    - trap still has priority over this check.
//  PC_MISALIGN_CHECK_EN undefined:
//    - No check; misalign_fault is tied 0.
//    - Misaligned targets load as-is (bit0 cleared).
// TESTING
//  1. reset high, then release -> pc=0, pc_valid=0 for 1 cycle; then pc_valid=1.
//     With fetch_ready=1: pc steps 0,4,8,...
//  2. RUN, jump=1 with branch_condition_match=1, target=0x101 -> pc=0x100, redirect=1 one cycle.
//  3. trap=1 with jump=1, trap_vector=0x80 -> pc=0x80. stall=1 and fetch_ready=0 do not block
//     the redirect.
//  4. pc=0x20: stall=1 or fetch_ready=0 for 3 cycles -> pc stays 0x20.
//     halt_req -> halted=1, pc_valid=0. resume -> RUN at 0x20.
//  5. RESET_VECTOR=0xFFFFFFFC, fetch_ready=1 -> pc wraps to 0x00000000 on the next fire.
//  6. Macro on, jump target=0x102, trap_vector=0x40 -> pc=0x40, misalign_fault=1 one cycle.
//     Macro off -> pc=0x102, misalign_fault=0.

Source files
------------

// File: rtl/pc_gen_unit.sv
// Fetch-PC generator: PC register, next-PC select, BOOT/RUN/HALT control and trap redirect.
// Optional build macro PC_MISALIGN_CHECK_EN turns misaligned jump/branch targets into a trap redirect.
module pc_gen_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                INC          = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            jump,
    input  logic            branch_condition_match,
    input  logic [XLEN-1:0] target_addr,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc_increment,
    output logic            redirect,
    output logic            halted,
    output logic            misalign_fault
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            r_redirect;
    logic            w_redirect_next;
    logic            r_misalign;
    logic            w_misalign_next;

    logic            w_fire;
    logic            w_jb_req;
    logic            w_misaligned;
    logic [XLEN-1:0] w_target_clr;
    logic            w_unused_target_lsb;

    assign w_target_clr        = {target_addr[XLEN-1:1], 1'b0};
    assign w_unused_target_lsb = target_addr[0];
    assign w_jb_req            = jump | branch_condition_match;
    assign w_fire              = pc_valid & fetch_ready;

`ifdef PC_MISALIGN_CHECK_EN
    assign w_misaligned = w_jb_req & w_target_clr[1];
`else
    assign w_misaligned = 1'b0;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_redirect_next = 1'b0;
        w_misalign_next = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                // Redirects beat stall/fetch_ready; a same-cycle halt stops at the new PC.
                if (trap) begin
                    w_pc_next       = trap_vector;
                    w_redirect_next = 1'b1;
                end else if (w_misaligned) begin
                    w_pc_next       = trap_vector;
                    w_redirect_next = 1'b1;
                    w_misalign_next = 1'b1;
                end else if (w_jb_req) begin
                    w_pc_next       = w_target_clr;
                    w_redirect_next = 1'b1;
                end else if (w_fire && !stall) begin
                    w_pc_next = pc_increment;
                end
                if (halt_req) begin
                    w_state_next = S_HALT;
                end
            end
            S_HALT: begin
                if (trap) begin
                    w_pc_next       = trap_vector;
                    w_redirect_next = 1'b1;
                    w_state_next    = S_RUN;
                end else if (resume) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VECTOR;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_redirect <= w_redirect_next;
            r_misalign <= w_misalign_next;
        end
    end

    assign pc             = r_pc;
    assign pc_increment   = r_pc + XLEN'(INC);
    assign pc_valid       = (r_state == S_RUN);
    assign halted         = (r_state == S_HALT);
    assign redirect       = r_redirect;
    assign misalign_fault = r_misalign;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: stimulus pushes hand-computed post-edge state,
// a monitor pops and compares one entry per clock.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        trap = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        jump = 1'b0;
    logic        branch_condition_match = 1'b0;
    logic [31:0] target_addr = '0;
    logic        fetch_ready = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] pc_increment;
    logic        redirect;
    logic        halted;
    logic        misalign_fault;

    pc_gen_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .INC(4)) u_dut (
        .clk                    (clk),
        .reset                  (reset),
        .stall                  (stall),
        .halt_req               (halt_req),
        .resume                 (resume),
        .trap                   (trap),
        .trap_vector            (trap_vector),
        .jump                   (jump),
        .branch_condition_match (branch_condition_match),
        .target_addr            (target_addr),
        .fetch_ready            (fetch_ready),
        .pc                     (pc),
        .pc_valid               (pc_valid),
        .pc_increment           (pc_increment),
        .redirect               (redirect),
        .halted                 (halted),
        .misalign_fault         (misalign_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [3:0]  flags;   // {pc_valid, redirect, halted, misalign_fault}
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // ctl = {reset, trap, jump, branch, stall, fetch_ready, halt_req, resume}
    task automatic cyc(input string nm, input logic [7:0] ctl, input logic [31:0] tv,
                       input logic [31:0] ta, input logic [31:0] epc, input logic [3:0] eflags);
        exp_t e;
        @(negedge clk);
        reset                  = ctl[7];
        trap                   = ctl[6];
        jump                   = ctl[5];
        branch_condition_match = ctl[4];
        stall                  = ctl[3];
        fetch_ready            = ctl[2];
        halt_req               = ctl[1];
        resume                 = ctl[0];
        trap_vector            = tv;
        target_addr            = ta;
        e.name  = nm;
        e.pc    = epc;
        e.flags = eflags;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [3:0]  act;
        logic [31:0] inc_exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e       = exp_q.pop_front();
                act     = {pc_valid, redirect, halted, misalign_fault};
                inc_exp = e.pc + 32'd4;
                n_tests++;
                if (pc !== e.pc || act !== e.flags) begin
                    n_fail++;
                    $display("FAIL %s: pc=%08h flags(v,r,h,m)=%04b, required pc=%08h flags=%04b",
                             e.name, pc, act, e.pc, e.flags);
                end
                n_tests++;
                if (pc_increment !== inc_exp) begin
                    n_fail++;
                    $display("FAIL %s_inc: pc_increment=%08h, required %08h",
                             e.name, pc_increment, inc_exp);
                end
                $display("[TB] %s pc=%08h flags=%04b", e.name, pc, act);
            end
        end
    end

    initial begin : stimulus
        int guard;
        cyc("reset0",     8'h80, 32'h0,        32'h0,   32'h0,        4'b0000);
        cyc("reset1",     8'h84, 32'h0,        32'h0,   32'h0,        4'b0000);
        cyc("boot",       8'h04, 32'h0,        32'h0,   32'h0,        4'b1000);
        cyc("seq4",       8'h04, 32'h0,        32'h0,   32'h4,        4'b1000);
        cyc("seq8",       8'h04, 32'h0,        32'h0,   32'h8,        4'b1000);
        cyc("seqC",       8'h04, 32'h0,        32'h0,   32'hC,        4'b1000);
        cyc("jump_br",    8'h34, 32'h0,        32'h101, 32'h100,      4'b1100);
        cyc("post_jump",  8'h04, 32'h0,        32'h0,   32'h104,      4'b1000);
        cyc("br_stall",   8'h18, 32'h0,        32'h201, 32'h200,      4'b1100);
        cyc("trap_prio",  8'h68, 32'h80,       32'h300, 32'h80,       4'b1100);
        cyc("jump20",     8'h24, 32'h0,        32'h20,  32'h20,       4'b1100);
        cyc("stall1",     8'h0C, 32'h0,        32'h0,   32'h20,       4'b1000);
        cyc("stall2",     8'h0C, 32'h0,        32'h0,   32'h20,       4'b1000);
        cyc("not_ready",  8'h00, 32'h0,        32'h0,   32'h20,       4'b1000);
        cyc("halt",       8'h02, 32'h0,        32'h0,   32'h20,       4'b0010);
        cyc("halt_ign",   8'h2C, 32'h0,        32'h500, 32'h20,       4'b0010);
        cyc("resume",     8'h01, 32'h0,        32'h0,   32'h20,       4'b1000);
        cyc("seq24",      8'h04, 32'h0,        32'h0,   32'h24,       4'b1000);
        cyc("jump_halt",  8'h22, 32'h0,        32'h40,  32'h40,       4'b0110);
        cyc("halt_trap",  8'h40, 32'h1000,     32'h0,   32'h1000,     4'b1100);
        cyc("trap_hi",    8'h40, 32'hFFFFFFF8, 32'h0,   32'hFFFFFFF8, 4'b1100);
        cyc("seq_top",    8'h04, 32'h0,        32'h0,   32'hFFFFFFFC, 4'b1000);
        cyc("wrap",       8'h04, 32'h0,        32'h0,   32'h0,        4'b1000);
`ifdef PC_MISALIGN_CHECK_EN
        cyc("misalign",   8'h24, 32'h40,       32'h102, 32'h40,       4'b1101);
        cyc("post_mis",   8'h04, 32'h0,        32'h0,   32'h44,       4'b1000);
        cyc("halt2",      8'h02, 32'h0,        32'h0,   32'h44,       4'b0010);
`else
        cyc("misalign",   8'h24, 32'h40,       32'h102, 32'h102,      4'b1100);
        cyc("post_mis",   8'h04, 32'h0,        32'h0,   32'h106,      4'b1000);
        cyc("halt2",      8'h02, 32'h0,        32'h0,   32'h106,      4'b0010);
`endif
        cyc("reset_halt", 8'h80, 32'h0,        32'h0,   32'h0,        4'b0000);
        cyc("reboot",     8'h04, 32'h0,        32'h0,   32'h0,        4'b1000);
        cyc("reseq4",     8'h04, 32'h0,        32'h0,   32'h4,        4'b1000);

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
